// File: rtl/fsmotor_stepgen.sv
// rtl/fsmotor_stepgen.sv - N-channel stepper move generator between control plane and motor driver pins
//
// Purpose: each channel takes a move command (step count, half-period, direction,
// microstep), holds DIR stable for a setup delay, then emits step pulses with a
// period of exactly 2*speed clocks. A move may be aborted (s_stop) or, when homing
// is requested, ended by the synchronised zero-point sensor.
//
// Ports:
//   clk, resetn             system clock, asynchronous active-low reset
//   s_xen, s_xrst           driver enable/reset requests, registered onto m_xen/m_xrst
//   s_start, s_stop         per-channel start / abort pulses
//   s_home, s_dir, s_ms,
//   s_step, s_speed         command fields, latched on an accepted start
//   s_busy, s_done          move in progress / one-cycle end-of-move pulse
//   s_zstop                 sticky: last move ended by zero-point
//   s_zpd, m_zpd            synchronised / raw zero-point sensor
//   m_ms, m_dir, m_drive    latched microstep, direction, step pulse

module fsmotor_stepgen #(
    parameter int C_CHANNEL_NUM       = 6,
    parameter int C_MICROSTEP_WIDTH   = 3,
    parameter int C_STEP_NUMBER_WIDTH = 16,
    parameter int C_SPEED_DATA_WIDTH  = 16,
    parameter int C_DIR_SETUP         = 8
) (
    input  logic                                         clk,
    input  logic                                         resetn,
    input  logic [C_CHANNEL_NUM-1:0]                     s_xen,
    input  logic [C_CHANNEL_NUM-1:0]                     s_xrst,
    input  logic [C_CHANNEL_NUM-1:0]                     s_start,
    input  logic [C_CHANNEL_NUM-1:0]                     s_stop,
    input  logic [C_CHANNEL_NUM-1:0]                     s_home,
    input  logic [C_CHANNEL_NUM-1:0]                     s_dir,
    input  logic [C_CHANNEL_NUM*C_MICROSTEP_WIDTH-1:0]   s_ms,
    input  logic [C_CHANNEL_NUM*C_STEP_NUMBER_WIDTH-1:0] s_step,
    input  logic [C_CHANNEL_NUM*C_SPEED_DATA_WIDTH-1:0]  s_speed,
    output logic [C_CHANNEL_NUM-1:0]                     s_busy,
    output logic [C_CHANNEL_NUM-1:0]                     s_done,
    output logic [C_CHANNEL_NUM-1:0]                     s_zstop,
    output logic [C_CHANNEL_NUM-1:0]                     s_zpd,
    input  logic [C_CHANNEL_NUM-1:0]                     m_zpd,
    output logic [C_CHANNEL_NUM-1:0]                     m_xen,
    output logic [C_CHANNEL_NUM-1:0]                     m_xrst,
    output logic [C_CHANNEL_NUM*C_MICROSTEP_WIDTH-1:0]   m_ms,
    output logic [C_CHANNEL_NUM-1:0]                     m_drive,
    output logic [C_CHANNEL_NUM-1:0]                     m_dir
);

    localparam int N  = C_CHANNEL_NUM;
    localparam int MS = C_MICROSTEP_WIDTH;
    localparam int SW = C_STEP_NUMBER_WIDTH;
    localparam int PW = C_SPEED_DATA_WIDTH;

    // The setup counter shares the phase counter; it runs from C_DIR_SETUP down
    // to 0 inclusive, so SETUP lasts C_DIR_SETUP+1 cycles and the first rising
    // DRIVE edge lands C_DIR_SETUP+1 cycles after the start is sampled.
    localparam logic [PW-1:0] SETUP_LOAD = PW'(C_DIR_SETUP);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    logic [N-1:0] zpd_meta;
    logic [N-1:0] zpd_sync;

    // Driver enable/reset pass-through and zero-point synchroniser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_xen    <= '0;
            m_xrst   <= '0;
            zpd_meta <= '0;
            zpd_sync <= '0;
        end else begin
            m_xen    <= s_xen;
            m_xrst   <= s_xrst;
            zpd_meta <= m_zpd;
            zpd_sync <= zpd_meta;
        end
    end

    assign s_zpd = zpd_sync;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            state_t          state;
            state_t          state_nx;
            logic [PW-1:0]   cnt;
            logic [PW-1:0]   cnt_nx;
            logic [SW-1:0]   rem;
            logic [SW-1:0]   rem_nx;
            logic [PW-1:0]   speed;
            logic [MS-1:0]   ms;
            logic            dir;
            logic            home;
            logic            drive;
            logic            zstop;
            logic            stop_pend;
            logic            stop_pend_nx;
            logic            zero_pend;
            logic            zero_pend_nx;
            logic            latch;
            logic            req_stop;
            logic            req_zero;
            logic [SW-1:0]   cmd_step;
            logic [PW-1:0]   cmd_speed;

            assign cmd_step  = s_step[i*SW +: SW];
            assign cmd_speed = s_speed[i*PW +: PW];

            // A request seen this cycle counts together with one recorded earlier.
            assign req_stop = stop_pend | s_stop[i];
            assign req_zero = zero_pend | (home & zpd_sync[i]);

            always_comb begin
                state_nx     = state;
                cnt_nx       = cnt;
                rem_nx       = rem;
                stop_pend_nx = stop_pend;
                zero_pend_nx = zero_pend;
                latch        = 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (s_start[i]) begin
                            latch        = 1'b1;
                            rem_nx       = cmd_step;
                            cnt_nx       = SETUP_LOAD;
                            stop_pend_nx = 1'b0;
                            zero_pend_nx = 1'b0;
                            state_nx     = (cmd_step == '0) ? ST_DONE : ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        // No pulse has been issued yet, so any request ends the move now.
                        zero_pend_nx = home & zpd_sync[i];
                        if (s_stop[i] || (home && zpd_sync[i])) begin
                            state_nx = ST_DONE;
                        end else if (cnt == '0) begin
                            state_nx = ST_HIGH;
                            cnt_nx   = speed - 1'b1;
                        end else begin
                            cnt_nx = cnt - 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        stop_pend_nx = req_stop;
                        zero_pend_nx = req_zero;
                        if (cnt == '0) begin
                            state_nx = ST_LOW;
                            cnt_nx   = speed - 1'b1;
                        end else begin
                            cnt_nx = cnt - 1'b1;
                        end
                    end
                    ST_LOW: begin
                        stop_pend_nx = req_stop;
                        zero_pend_nx = req_zero;
                        if (cnt == '0) begin
                            rem_nx = rem - 1'b1;
                            // rem is never 0 here: a zero-step move skips straight to DONE.
                            if (rem == SW'(1) || req_stop || req_zero) begin
                                state_nx = ST_DONE;
                            end else begin
                                state_nx = ST_HIGH;
                                cnt_nx   = speed - 1'b1;
                            end
                        end else begin
                            cnt_nx = cnt - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_nx = ST_IDLE;
                    end
                    default: begin
                        state_nx = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    rem       <= '0;
                    speed     <= '0;
                    ms        <= '0;
                    dir       <= 1'b0;
                    home      <= 1'b0;
                    drive     <= 1'b0;
                    zstop     <= 1'b0;
                    stop_pend <= 1'b0;
                    zero_pend <= 1'b0;
                end else begin
                    state     <= state_nx;
                    cnt       <= cnt_nx;
                    rem       <= rem_nx;
                    stop_pend <= stop_pend_nx;
                    zero_pend <= zero_pend_nx;
                    drive     <= (state_nx == ST_HIGH);
                    if (latch) begin
                        dir   <= s_dir[i];
                        ms    <= s_ms[i*MS +: MS];
                        home  <= s_home[i];
                        speed <= (cmd_speed == '0) ? PW'(1) : cmd_speed;
                        zstop <= 1'b0;
                    end else if (state != ST_DONE && state_nx == ST_DONE && zero_pend_nx) begin
                        // Set on DONE entry so it is valid alongside s_done.
                        zstop <= 1'b1;
                    end
                end
            end

            assign s_busy[i]          = (state != ST_IDLE);
            assign s_done[i]          = (state == ST_DONE);
            assign s_zstop[i]         = zstop;
            assign m_drive[i]         = drive;
            assign m_dir[i]           = dir;
            assign m_ms[i*MS +: MS]   = ms;
        end
    endgenerate

endmodule
